inbuf: RTL and testbench

Input-port buffer for one switch ingress. It queues incoming flits in a FIFO and decodes the destination from each packet's header flit. It then holds exactly one request line to the four per-output round-robin arbiters (`arb`) and forwards the packet toward the crossbar one flit per cycle, only while that arbiter's ack is high. One instance sits directly upstream of the arbiters on each input port.

---
 rtl/inbuf_pkg.sv | 19 +
 rtl/inbuf_fifo.sv | 54 +++++
 rtl/inbuf.sv | 125 ++++++++++++
 tb/tb_inbuf.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inbuf_pkg.sv
// Shared constants for the ingress buffer: assert/negate levels, FSM encodings, destination width.
package inbuf_pkg;

    localparam logic ASSERT = 1'b1;
    localparam logic NEGATE = 1'b0;

    localparam int DEST_W = 2;

    typedef enum logic [1:0] {
        INBUF_IDLE    = 2'd0,
        INBUF_ACTIVE  = 2'd1,
        INBUF_RELEASE = 2'd2
    } inbuf_state_e;

    function automatic logic [3:0] dest_onehot(input logic [DEST_W-1:0] dest);
        return 4'b0001 << dest;
    endfunction

endpackage

// File: rtl/inbuf_fifo.sv
// Flit FIFO: storage of {last, data}, extra-MSB pointers for full/empty.
// Pushed entry is visible at the head one cycle later; push ignored when full, pop ignored when empty.
module inbuf_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic [DATA_W:0] push_dat,
    input  logic            pop,
    output logic [DATA_W:0] head_dat,
    output logic            full,
    output logic            empty
);
    import inbuf_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W:0] mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            push_ok, pop_ok;

    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign head_dat = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push_ok);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the pointers define which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok == ASSERT) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_dat;
        end
    end

endmodule

// File: rtl/inbuf.sv
// Ingress buffer: queues flits, latches header dest, holds one arbiter request and forwards on ack.
// Header at head -> req next cycle; flits leave 1/cycle while ack[dest] high. INBUF_CUT_THROUGH_EN selects cut-through.
module inbuf #(
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 8,
    parameter int DEST_LSB = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] idata,
    input  logic              ilast,
    input  logic              ivalid,
    output logic              iready,
    output logic              req0,
    output logic              req1,
    output logic              req2,
    output logic              req3,
    input  logic              ack0,
    input  logic              ack1,
    input  logic              ack2,
    input  logic              ack3,
    output logic [DATA_W-1:0] odata,
    output logic              olast,
    output logic              ovalid
);
    import inbuf_pkg::*;

    inbuf_state_e      state_q, state_d;
    logic [DEST_W-1:0] dest_q, dest_d;
    logic [3:0]        req_q, req_d;
    logic [3:0]        ack_vec;
    logic [DATA_W:0]   head_dat;
    logic              head_last;
    logic              full, empty, push, pop, eligible;

    assign ack_vec   = {ack3, ack2, ack1, ack0};
    assign head_last = head_dat[DATA_W];
    assign push      = ivalid & ~full;
    assign iready    = full ? NEGATE : ASSERT;
    assign pop       = (state_q == INBUF_ACTIVE) & ack_vec[dest_q] & ~empty;

    assign ovalid = pop;
    assign odata  = pop ? head_dat[DATA_W-1:0] : '0;
    assign olast  = pop & head_last;
    assign {req3, req2, req1, req0} = req_q;

    inbuf_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat ({ilast, idata}),
        .pop      (pop),
        .head_dat (head_dat),
        .full     (full),
        .empty    (empty)
    );

`ifdef INBUF_CUT_THROUGH_EN
    assign eligible = ~empty;
`else
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

    // Count of tails currently stored: a packet may only start once it is entirely buffered.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q + CNT_W'(push & ilast) - CNT_W'(pop & head_last);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign eligible = (pkt_cnt_q != '0);
`endif

    // In IDLE the head is always a header: we only return there after popping a tail.
    always_comb begin
        state_d = state_q;
        dest_d  = dest_q;
        req_d   = req_q;
        case (state_q)
            INBUF_IDLE: begin
                if (eligible) begin
                    state_d = INBUF_ACTIVE;
                    dest_d  = head_dat[DEST_LSB +: DEST_W];
                    req_d   = dest_onehot(head_dat[DEST_LSB +: DEST_W]);
                end
            end
            INBUF_ACTIVE: begin
                if (pop && head_last) begin
                    state_d = INBUF_RELEASE;
                    req_d   = {4{NEGATE}};
                end
            end
            INBUF_RELEASE: begin
                state_d = INBUF_IDLE;
            end
            default: begin
                state_d = INBUF_IDLE;
                req_d   = {4{NEGATE}};
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INBUF_IDLE;
            dest_q  <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            dest_q  <= dest_d;
            req_q   <= req_d;
        end
    end

endmodule

// File: tb/tb_inbuf.sv
// Directed scenarios plus a randomized run checked against a flit-queue reference model.
module tb_inbuf;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 8;

    typedef struct {
        logic [15:0] d;
        logic        l;
        logic [1:0]  dst;
    } flit_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] idata;
    logic        ilast;
    logic        ivalid;
    logic        iready;
    logic        req0, req1, req2, req3;
    logic [3:0]  ack;
    logic [15:0] odata;
    logic        olast;
    logic        ovalid;
    logic [3:0]  req;

    int total = 0;
    int bad   = 0;

    flit_t gen_q[$];
    flit_t exp_q[$];

    always #5 clk = ~clk;

    assign req = {req3, req2, req1, req0};

    inbuf #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .DEST_LSB (0)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .idata  (idata),
        .ilast  (ilast),
        .ivalid (ivalid),
        .iready (iready),
        .req0   (req0),
        .req1   (req1),
        .req2   (req2),
        .req3   (req3),
        .ack0   (ack[0]),
        .ack1   (ack[1]),
        .ack2   (ack[2]),
        .ack3   (ack[3]),
        .odata  (odata),
        .olast  (olast),
        .ovalid (ovalid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: wait for the edge, drive this cycle's inputs, let outputs settle.
    task automatic step(input logic v, input logic [15:0] d, input logic l, input logic [3:0] a);
        @(posedge clk);
        #1;
        ivalid = v;
        idata  = d;
        ilast  = l;
        ack    = a;
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [15:0] d, input logic l);
        chk({tag, "_ovalid"}, 32'(ovalid), 32'(1'b1));
        chk({tag, "_odata"},  32'(odata),  32'(d));
        chk({tag, "_olast"},  32'(olast),  32'(l));
    endtask

    task automatic wait_req(input int n, input string tag);
        int k;
        k = 0;
        while (req[n] !== 1'b1 && k < 30) begin
            step(1'b0, 16'h0, 1'b0, 4'h0);
            k++;
        end
        chk(tag, 32'(req), 32'(4'(1) << n));
    endtask

    task automatic release_chk(input string tag, input logic [3:0] a);
        step(1'b0, 16'h0, 1'b0, a);
        chk({tag, "_rel_req"},    32'(req),    32'(4'h0));
        chk({tag, "_rel_ovalid"}, 32'(ovalid), 32'(1'b0));
        step(1'b0, 16'h0, 1'b0, 4'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int gap;
        int cycles;
        logic       v;
        logic [3:0] a;
        logic       exp_ov;
        flit_t      f;

        rst    = 1'b1;
        ivalid = 1'b0;
        idata  = '0;
        ilast  = 1'b0;
        ack    = '0;
        step(1'b0, 16'h0, 1'b0, 4'h0);
        step(1'b0, 16'h0, 1'b0, 4'hF);
        chk("rst_req",    32'(req),    32'(4'h0));
        chk("rst_ovalid", 32'(ovalid), 32'(1'b0));
        chk("rst_odata",  32'(odata),  32'(16'h0));
        chk("rst_olast",  32'(olast),  32'(1'b0));
        chk("rst_iready", 32'(iready), 32'(1'b1));
        rst = 1'b0;

        // 3-flit packet to port 2, ack one cycle after req.
`ifdef INBUF_CUT_THROUGH_EN
        step(1'b1, 16'hA002, 1'b0, 4'h0);
        step(1'b1, 16'h1111, 1'b0, 4'h0);
        chk("t1_req_pre", 32'(req), 32'(4'h0));
        step(1'b1, 16'h2222, 1'b1, 4'h0);
        chk("t1_req", 32'(req), 32'(4'b0100));
`else
        step(1'b1, 16'hA002, 1'b0, 4'h0);
        step(1'b1, 16'h1111, 1'b0, 4'h0);
        step(1'b1, 16'h2222, 1'b1, 4'h0);
        step(1'b0, 16'h0, 1'b0, 4'h0);
        chk("t1_req_pre", 32'(req), 32'(4'h0));
        step(1'b0, 16'h0, 1'b0, 4'h0);
        chk("t1_req", 32'(req), 32'(4'b0100));
`endif
        step(1'b0, 16'h0, 1'b0, 4'b0100);
        expect_out("t1_f0", 16'hA002, 1'b0);
        step(1'b0, 16'h0, 1'b0, 4'b0100);
        expect_out("t1_f1", 16'h1111, 1'b0);
        step(1'b0, 16'h0, 1'b0, 4'b0100);
        expect_out("t1_f2", 16'h2222, 1'b1);
        release_chk("t1", 4'b0100);

        // Same packet, ack dropped for two cycles after the first flit.
        step(1'b1, 16'hA002, 1'b0, 4'h0);
        step(1'b1, 16'h1111, 1'b0, 4'h0);
        step(1'b1, 16'h2222, 1'b1, 4'h0);
        wait_req(2, "t2_req");
        step(1'b0, 16'h0, 1'b0, 4'b0100);
        expect_out("t2_f0", 16'hA002, 1'b0);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 16'h0, 1'b0, 4'b1011);
            chk("t2_stall_ovalid", 32'(ovalid), 32'(1'b0));
            chk("t2_stall_req",    32'(req),    32'(4'b0100));
        end
        step(1'b0, 16'h0, 1'b0, 4'b0100);
        expect_out("t2_f1", 16'h1111, 1'b0);
        step(1'b0, 16'h0, 1'b0, 4'b0100);
        expect_out("t2_f2", 16'h2222, 1'b1);
        release_chk("t2", 4'b0100);

        // Back-to-back packets: dest 1 (2 flits) then dest 3 (single flit).
        step(1'b1, 16'h0001, 1'b0, 4'h0);
        step(1'b1, 16'h5555, 1'b1, 4'h0);
        step(1'b1, 16'h0003, 1'b1, 4'h0);
        wait_req(1, "t3_req1");
        step(1'b0, 16'h0, 1'b0, 4'b1010);
        expect_out("t3_a0", 16'h0001, 1'b0);
        step(1'b0, 16'h0, 1'b0, 4'b1010);
        expect_out("t3_a1", 16'h5555, 1'b1);
        gap = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 16'h0, 1'b0, 4'b1010);
            if (req[3] === 1'b1) break;
            chk("t3_gap_req",    32'(req),    32'(4'h0));
            chk("t3_gap_ovalid", 32'(ovalid), 32'(1'b0));
            gap++;
        end
        chk("t3_gap_ge2", 32'(gap >= 2), 32'(1'b1));
        chk("t3_req3", 32'(req), 32'(4'b1000));
        expect_out("t3_b0", 16'h0003, 1'b1);
        release_chk("t3", 4'b1010);

        // Fill all entries with no ack, then a single pop frees one slot.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, (i == 0) ? 16'h0000 : 16'(16'h4000 + i), (i == DEPTH - 1), 4'h0);
            chk("t4_iready_fill", 32'(iready), 32'(1'b1));
        end
        step(1'b1, 16'hDEAD, 1'b1, 4'h0);
        chk("t4_iready_full", 32'(iready), 32'(1'b0));
        wait_req(0, "t4_req0");
        chk("t4_iready_still_full", 32'(iready), 32'(1'b0));
        step(1'b0, 16'h0, 1'b0, 4'b0001);
        expect_out("t4_f0", 16'h0000, 1'b0);
        step(1'b0, 16'h0, 1'b0, 4'h0);
        chk("t4_iready_after_pop", 32'(iready), 32'(1'b1));
        chk("t4_single_pop",       32'(ovalid), 32'(1'b0));
        for (int i = 1; i < DEPTH; i++) begin
            step(1'b0, 16'h0, 1'b0, 4'b0001);
            expect_out("t4_drain", 16'(16'h4000 + i), (i == DEPTH - 1));
        end
        release_chk("t4", 4'b0001);

        // Header dest 0 with the tail held back five cycles.
        step(1'b1, 16'h0000, 1'b0, 4'h0);
`ifdef INBUF_CUT_THROUGH_EN
        step(1'b0, 16'h0, 1'b0, 4'h0);
        chk("t5_req_hdr_head", 32'(req), 32'(4'h0));
        step(1'b0, 16'h0, 1'b0, 4'h0);
        chk("t5_req_ct", 32'(req), 32'(4'b0001));
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0, 1'b0, 4'h0);
            chk("t5_req_ct_hold", 32'(req), 32'(4'b0001));
        end
        step(1'b1, 16'h7777, 1'b1, 4'h0);
`else
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 16'h0, 1'b0, 4'h0);
            chk("t5_req_hold_low", 32'(req), 32'(4'h0));
        end
        step(1'b1, 16'h7777, 1'b1, 4'h0);
        chk("t5_req_tail_cycle", 32'(req), 32'(4'h0));
        step(1'b0, 16'h0, 1'b0, 4'h0);
        chk("t5_req_after_tail", 32'(req), 32'(4'h0));
        step(1'b0, 16'h0, 1'b0, 4'h0);
        chk("t5_req_rise", 32'(req), 32'(4'b0001));
`endif
        wait_req(0, "t5_req0");
        step(1'b0, 16'h0, 1'b0, 4'b0001);
        expect_out("t5_f0", 16'h0000, 1'b0);
        step(1'b0, 16'h0, 1'b0, 4'b0001);
        expect_out("t5_f1", 16'h7777, 1'b1);
        release_chk("t5", 4'b0001);

        // Reset while a packet is in flight.
        step(1'b1, 16'h0011, 1'b0, 4'h0);
        step(1'b1, 16'h0BBB, 1'b0, 4'h0);
        step(1'b1, 16'h0CCC, 1'b1, 4'h0);
        wait_req(1, "t6_req1");
        step(1'b0, 16'h0, 1'b0, 4'b0010);
        expect_out("t6_f0", 16'h0011, 1'b0);
        rst = 1'b1;
        step(1'b0, 16'h0, 1'b0, 4'b0010);
        rst = 1'b0;
        chk("t6_rst_req",    32'(req),    32'(4'h0));
        chk("t6_rst_ovalid", 32'(ovalid), 32'(1'b0));
        chk("t6_rst_iready", 32'(iready), 32'(1'b1));
        step(1'b1, 16'h0002, 1'b1, 4'h0);
        wait_req(2, "t6_req2");
        step(1'b0, 16'h0, 1'b0, 4'b0100);
        expect_out("t6_new", 16'h0002, 1'b1);
        release_chk("t6", 4'b0100);

        // Randomized traffic against the flit-queue model.
        for (int p = 0; p < 60; p++) begin
            int len;
            logic [1:0] dst;
            len = $urandom_range(1, DEPTH);
            dst = 2'($urandom_range(0, 3));
            for (int k = 0; k < len; k++) begin
                f.d   = (k == 0) ? {16'($urandom) & 16'hFFFC} | 16'(dst) : 16'($urandom);
                f.l   = (k == len - 1);
                f.dst = dst;
                gen_q.push_back(f);
            end
        end
        cycles = 0;
        while ((gen_q.size() > 0 || exp_q.size() > 0) && cycles < 6000) begin
            cycles++;
            v = (gen_q.size() > 0) && ($urandom_range(0, 9) < 7);
            for (int n = 0; n < 4; n++) begin
                a[n] = (req[n] === 1'b1) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 3);
            end
            if (v) step(1'b1, gen_q[0].d, gen_q[0].l, a);
            else   step(1'b0, 16'h0, 1'b0, a);
            exp_ov = (req != 4'h0) && ((req & ack) != 4'h0) && (exp_q.size() > 0);
            if (req != 4'h0 && exp_q.size() > 0) begin
                chk("rand_req_dest", 32'(req), 32'(4'(1) << exp_q[0].dst));
            end
            chk("rand_ovalid", 32'(ovalid), 32'(exp_ov));
            if (ovalid === 1'b1 && exp_q.size() > 0) begin
                f = exp_q.pop_front();
                chk("rand_odata", 32'(odata), 32'(f.d));
                chk("rand_olast", 32'(olast), 32'(f.l));
            end
            if (v && iready === 1'b1) begin
                exp_q.push_back(gen_q.pop_front());
            end
        end
        chk("rand_drained", 32'(gen_q.size() + exp_q.size()), 32'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
